// File: rtl/jio_cycle_gen_if.sv
// Request/response handshake plus JERRY I/O pin bundle for jio_cycle_gen.
// slave = the cycle generator, master = the local host/bridge and pin model.
interface jio_cycle_gen_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [15:0] a;
  logic        dspcsl;
  logic        dspen;
  logic        wel0;
  logic        oel0;
  logic [15:0] dr_out;
  logic        dr_oe;
  logic [15:0] dr_in;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, dr_in,
    output req_ready, rsp_valid, rsp_rdata,
    output a, dspcsl, dspen, wel0, oel0, dr_out, dr_oe
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, dr_in,
    input  req_ready, rsp_valid, rsp_rdata,
    input  a, dspcsl, dspen, wel0, oel0, dr_out, dr_oe
  );
endinterface

// File: rtl/jio_cycle_gen.sv
// JERRY I/O bus-cycle initiator: setup/strobe/hold sequencing, all pins registered.
// rsp_valid SETUP+STROBE+HOLD+1 cycles after accept; req_ready low while a cycle runs.
module jio_cycle_gen #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic           sys_clk,
  input  logic           resetl,
  jio_cycle_gen_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  logic [1:0]  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        wr_q, wr_nxt;
  logic [15:0] addr_q, addr_nxt;
  logic [15:0] wdata_q, wdata_nxt;
  logic        capture;
  logic        rsp_nxt;
  logic        active_nxt;
  logic        strobe_nxt;

  logic        rsp_valid_q;
  logic [15:0] rdata_q;
  logic [15:0] a_q;
  logic        csl_q;
  logic        en_q;
  logic        wel_q;
  logic        oel_q;
  logic [15:0] dout_q;
  logic        oe_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_nxt    = wr_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    capture   = 1'b0;
    rsp_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          wr_nxt    = bus.req_wr;
          addr_nxt  = bus.req_addr;
          wdata_nxt = bus.req_wdata;
          cnt_nxt   = SETUP_LD;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt == 4'd0) begin
          cnt_nxt   = STROBE_LD;
          state_nxt = ST_STROBE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt == 4'd0) begin
          capture   = !wr_q;
          cnt_nxt   = HOLD_LD;
          state_nxt = ST_HOLD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt == 4'd0) begin
          rsp_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pins are registered from the next state so each phase shows on the bus
  // in the same cycle the FSM enters it, without any input-to-pin path.
  assign active_nxt = (state_nxt != ST_IDLE);
  assign strobe_nxt = (state_nxt == ST_STROBE);

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wr_q    <= wr_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      rsp_valid_q <= 1'b0;
      rdata_q     <= 16'h0000;
      a_q         <= 16'h0000;
      csl_q       <= 1'b1;
      en_q        <= 1'b0;
      wel_q       <= 1'b1;
      oel_q       <= 1'b1;
      dout_q      <= 16'h0000;
      oe_q        <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_nxt;
      if (capture) begin
        rdata_q <= bus.dr_in;
      end
      a_q    <= active_nxt ? addr_nxt : 16'h0000;
      csl_q  <= !active_nxt;
      en_q   <= active_nxt;
      wel_q  <= !(strobe_nxt && wr_nxt);
      oel_q  <= !(strobe_nxt && !wr_nxt);
      oe_q   <= active_nxt && wr_nxt;
      dout_q <= (active_nxt && wr_nxt) ? wdata_nxt : 16'h0000;
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.a         = a_q;
  assign bus.dspcsl    = csl_q;
  assign bus.dspen     = en_q;
  assign bus.wel0      = wel_q;
  assign bus.oel0      = oel_q;
  assign bus.dr_out    = dout_q;
  assign bus.dr_oe     = oe_q;

  a_strobe_excl: assert property (@(posedge sys_clk) disable iff (!resetl)
    !(!wel_q && !oel_q));
  a_strobe_cs: assert property (@(posedge sys_clk) disable iff (!resetl)
    (!wel_q || !oel_q) |-> !csl_q);

endmodule

// File: tb/tb_jio_cycle_gen.sv
// Randomised bench for jio_cycle_gen: per-cycle pin model plus response scoreboard.
module tb_jio_cycle_gen;
  localparam int S    = 2;
  localparam int T    = 4;
  localparam int H    = 3;
  localparam int L    = S + T + H;
  localparam int MAXC = 4096;

  logic clk    = 1'b0;
  logic resetl = 1'b0;
  int   cyc    = 0;

  jio_cycle_gen_if bus ();

  jio_cycle_gen #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
    .sys_clk (clk),
    .resetl  (resetl),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] dr_hist [MAXC];

  typedef struct {
    int          done;
    logic [15:0] rd;
  } rsp_t;
  rsp_t sb[$];

  // Reference model: the one transaction most recently accepted.
  bit          have     = 1'b0;
  int          acc      = 0;
  logic        m_wr     = 1'b0;
  logic [15:0] m_addr   = 16'h0;
  logic [15:0] m_wdata  = 16'h0;
  logic [15:0] m_rd     = 16'h0;
  logic [15:0] prev_rd  = 16'h0;
  logic [15:0] rd_after = 16'h0;

  int          k;
  logic        e_busy, e_ready, e_rsp, e_csl, e_en, e_wel, e_oel, e_oe;
  logic [15:0] e_a, e_dout, e_rd;
  rsp_t        r;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_req_ready"}, bus.req_ready, 1);
    chk({p, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({p, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({p, "_a"},         bus.a,         0);
    chk({p, "_dspcsl"},    bus.dspcsl,    1);
    chk({p, "_dspen"},     bus.dspen,     0);
    chk({p, "_wel0"},      bus.wel0,      1);
    chk({p, "_oel0"},      bus.oel0,      1);
    chk({p, "_dr_out"},    bus.dr_out,    0);
    chk({p, "_dr_oe"},     bus.dr_oe,     0);
  endtask

  initial begin
    forever begin
      #5 clk = 1'b1;
      cyc++;
      #5 clk = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    bus.dr_in = dr_hist[cyc % MAXC];
  end

  // Monitor: per-cycle pin expectations, scoreboard pop on rsp_valid, accept tracking.
  always @(negedge clk) begin
    if (!resetl) begin
      chk_reset("reset");
    end else begin
      k       = cyc - acc + 1;
      e_busy  = have && (k >= 1) && (k <= L);
      e_ready = !e_busy;
      e_rsp   = have && (k == L + 1);
      e_a     = e_busy ? m_addr : 16'h0;
      e_csl   = !e_busy;
      e_en    = e_busy;
      e_wel   = !(e_busy && m_wr && (k > S) && (k <= S + T));
      e_oel   = !(e_busy && !m_wr && (k > S) && (k <= S + T));
      e_oe    = e_busy && m_wr;
      e_dout  = (e_busy && m_wr) ? m_wdata : 16'h0;
      e_rd    = (have && !m_wr && (k > S + T)) ? m_rd : prev_rd;

      chk("req_ready", bus.req_ready, e_ready);
      chk("rsp_valid", bus.rsp_valid, e_rsp);
      chk("rsp_rdata", bus.rsp_rdata, e_rd);
      chk("a",         bus.a,         e_a);
      chk("dspcsl",    bus.dspcsl,    e_csl);
      chk("dspen",     bus.dspen,     e_en);
      chk("wel0",      bus.wel0,      e_wel);
      chk("oel0",      bus.oel0,      e_oel);
      chk("dr_oe",     bus.dr_oe,     e_oe);
      chk("dr_out",    bus.dr_out,    e_dout);

      if (bus.rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          r = sb.pop_front();
          chk("sb_rsp_cycle", cyc, r.done);
          chk("sb_rsp_rdata", bus.rsp_rdata, r.rd);
        end
      end

      if (e_ready && bus.req_valid) begin
        acc     = cyc + 1;
        have    = 1'b1;
        m_wr    = bus.req_wr;
        m_addr  = bus.req_addr;
        m_wdata = bus.req_wdata;
        prev_rd = rd_after;
        if (!m_wr) rd_after = dr_hist[(acc + S + T - 1) % MAXC];
        m_rd = rd_after;
        sb.push_back('{acc + L, rd_after});
      end
    end
  end

  task automatic issue(input logic wr, input logic [15:0] ad, input logic [15:0] wd,
                       output int acc_c);
    int w;
    w = 0;
    acc_c = -1;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = ad;
    bus.req_wdata = wd;
    while (acc_c < 0 && w < 100) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) acc_c = cyc + 1;
      w++;
    end
    chk("issue_accept", (acc_c >= 0), 1);
    @(posedge clk);
    #1;
    // Scramble the request fields while the cycle runs; the bus must not follow them.
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'($urandom);
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = 16'($urandom);
  endtask

  task automatic wait_idle();
    int w;
    bit ok;
    w  = 0;
    ok = 1'b0;
    while (!ok && w < 100) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) ok = 1'b1;
      w++;
    end
    chk("idle_reached", ok, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, a1;
    for (int i = 0; i < MAXC; i++) dr_hist[i] = 16'($urandom);
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 16'h0;
    bus.req_wdata = 16'h0;
    bus.dr_in     = 16'h0;

    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 resetl = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    issue(1'b1, 16'h0010, 16'h1234, a0);
    wait_idle();

    for (int i = 0; i < 40; i++) dr_hist[(cyc + i) % MAXC] = 16'hBEEF;
    issue(1'b0, 16'h4000, 16'h0000, a0);
    wait_idle();
    chk("read_beef", bus.rsp_rdata, 16'hBEEF);

    issue(1'b1, 16'h0022, 16'h5555, a0);
    wait_idle();
    chk("beef_held_after_write", bus.rsp_rdata, 16'hBEEF);

    issue(1'b1, 16'hA5A5, 16'h0F0F, a0);
    issue(1'b0, 16'h0101, 16'h0000, a1);
    chk("b2b_period", a1 - a0, L + 1);
    wait_idle();

    // Abort a write in its second STROBE cycle with an asynchronous reset.
    issue(1'b1, 16'h3C3C, 16'hC3C3, a0);
    do begin
      @(posedge clk);
      #3;
    end while (cyc < a0 + S + 1);
    chk("abort_pre_wel0", bus.wel0, 0);
    resetl = 1'b0;
    #1;
    chk_reset("abort");
    have     = 1'b0;
    sb.delete();
    prev_rd  = 16'h0;
    rd_after = 16'h0;
    @(posedge clk);
    #2 resetl = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b0, 16'h4321, 16'h0000, a0);
    wait_idle();

    repeat (700) begin
      @(posedge clk);
      #1;
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_wr    = 1'($urandom);
      bus.req_addr  = 16'($urandom);
      bus.req_wdata = 16'($urandom);
    end
    bus.req_valid = 1'b0;
    repeat (L + 5) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
